// File: rtl/dffsre_lut8_serializer.sv
// rtl/dffsre_lut8_serializer.sv - parallel-load serializer with valid/ready output and frame-done pulse
//
// Captures the registered dffsre/LUT word on LOAD and shifts it out one bit per
// accepted transfer (SO_VALID & SO_READY at posedge C). DONE pulses for one
// cycle when the last bit of a frame has been accepted.
//
// Optional feature macro: DFFSRE_SER_PARITY_EN
//   defined   - an even-parity bit of the captured word follows the data bits
//               (frame = WIDTH+1 bits)
//   undefined - frame = WIDTH data bits, no parity state or logic
//
// Parameters:
//   WIDTH      data bits per frame (>= 2)
//   MSB_FIRST  0: bit 0 first, 1: bit WIDTH-1 first
//
// Ports:
//   C         in   clock, all logic on posedge
//   R         in   synchronous active-low reset
//   Q_IN      in   parallel word to serialize
//   LOAD      in   capture request, honoured only while idle
//   SO_READY  in   sink accepts SO this cycle
//   SO        out  serial data bit (0 while idle)
//   SO_VALID  out  SO holds a valid bit
//   BUSY      out  frame in progress
//   DONE      out  one-cycle pulse after the last bit of a frame is accepted
//   CNT       out  data bits accepted in the current frame

module dffsre_lut8_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                       C,
    input  logic                       R,
    input  logic [WIDTH-1:0]           Q_IN,
    input  logic                       LOAD,
    input  logic                       SO_READY,
    output logic                       SO,
    output logic                       SO_VALID,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [$clog2(WIDTH+1)-1:0] CNT
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef DFFSRE_SER_PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'd2;
`endif

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic             last_data;
`ifdef DFFSRE_SER_PARITY_EN
    logic             par_bit;
`endif

    // The bit on SO is always the head of the shift register; a transfer
    // moves the next bit into the head position.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    always_comb begin
        shreg_nxt = '0;
        if (MSB_FIRST) begin
            shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    assign last_data = (CNT == CW'(WIDTH - 1));
    assign BUSY      = (state != ST_IDLE);
    assign SO_VALID  = BUSY;

    always_comb begin
        SO = 1'b0;
        if (state == ST_SHIFT) begin
            SO = head(shreg);
        end
`ifdef DFFSRE_SER_PARITY_EN
        else if (state == ST_PAR) begin
            SO = par_bit;
        end
`endif
    end

    always_ff @(posedge C) begin
        if (!R) begin
            state <= ST_IDLE;
            shreg <= '0;
            CNT   <= '0;
            DONE  <= 1'b0;
`ifdef DFFSRE_SER_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // LOAD in the DONE cycle lands here too, so frames can
                    // run with a single idle cycle between them.
                    if (LOAD) begin
                        shreg <= Q_IN;
                        CNT   <= '0;
                        state <= ST_SHIFT;
`ifdef DFFSRE_SER_PARITY_EN
                        par_bit <= ^Q_IN;
`endif
                    end
                end
                ST_SHIFT: begin
                    // SO_VALID is high in this state, so SO_READY alone
                    // qualifies a transfer; without it everything holds.
                    if (SO_READY) begin
                        shreg <= shreg_nxt;
                        if (last_data) begin
`ifdef DFFSRE_SER_PARITY_EN
                            state <= ST_PAR;
                            CNT   <= CW'(WIDTH);
`else
                            state <= ST_IDLE;
                            CNT   <= '0;
                            DONE  <= 1'b1;
`endif
                        end else begin
                            CNT <= CNT + 1'b1;
                        end
                    end
                end
`ifdef DFFSRE_SER_PARITY_EN
                ST_PAR: begin
                    if (SO_READY) begin
                        state <= ST_IDLE;
                        CNT   <= '0;
                        DONE  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    CNT   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dffsre_lut8_serializer.sv
// tb/tb_dffsre_lut8_serializer.sv - scoreboard bench for dffsre_lut8_serializer (LSB-first and MSB-first instances)

module tb_dffsre_lut8_serializer;

    localparam int W = 8;

    logic       C = 1'b0;
    logic       R;
    logic [7:0] q_in;
    logic       so_ready;
    logic       load_w     [2];
    logic       so_w       [2];
    logic       so_valid_w [2];
    logic       busy_w     [2];
    logic       done_w     [2];
    logic [3:0] cnt_w      [2];

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_on = 1'b0;

    // Scoreboard: expected serial bits per instance, front = bit on SO now.
    bit q      [2][$];
    bit m_busy [2];
    bit m_done [2];
    int m_cnt  [2];

    always #5 C = ~C;

    dffsre_lut8_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .C(C), .R(R), .Q_IN(q_in), .LOAD(load_w[0]), .SO_READY(so_ready),
        .SO(so_w[0]), .SO_VALID(so_valid_w[0]), .BUSY(busy_w[0]),
        .DONE(done_w[0]), .CNT(cnt_w[0])
    );

    dffsre_lut8_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .C(C), .R(R), .Q_IN(q_in), .LOAD(load_w[1]), .SO_READY(so_ready),
        .SO(so_w[1]), .SO_VALID(so_valid_w[1]), .BUSY(busy_w[1]),
        .DONE(done_w[1]), .CNT(cnt_w[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    // Frame bookkeeping from the sink's point of view.
    always @(posedge C) begin
        bit dummy;
        for (int i = 0; i < 2; i++) begin
            if (!R) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_cnt[i]  = 0;
                q[i].delete();
            end else begin
                m_done[i] = 1'b0;
                if (!m_busy[i]) begin
                    if (load_w[i]) begin
                        m_busy[i] = 1'b1;
                        m_cnt[i]  = 0;
                    end
                end else if (so_ready && q[i].size() > 0) begin
                    dummy = q[i].pop_front();
                    if (q[i].size() == 0) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                        m_cnt[i]  = 0;
                    end else begin
                        m_cnt[i]++;
                    end
                end
            end
        end
    end

    always @(negedge C) begin
        if (mon_on) begin
            for (int i = 0; i < 2; i++) begin
                int exp_so;
                exp_so = (m_busy[i] && q[i].size() > 0) ? int'(q[i][0]) : 0;
                check($sformatf("d%0d_so", i),    int'(so_w[i]),       exp_so);
                check($sformatf("d%0d_valid", i), int'(so_valid_w[i]), int'(m_busy[i]));
                check($sformatf("d%0d_busy", i),  int'(busy_w[i]),     int'(m_busy[i]));
                check($sformatf("d%0d_done", i),  int'(done_w[i]),     int'(m_done[i]));
                check($sformatf("d%0d_cnt", i),   int'(cnt_w[i]),      m_cnt[i]);
            end
        end
    end

    task automatic start(input int idx, input logic [7:0] w);
        load_w[idx] = 1'b1;
        q_in        = w;
        for (int b = 0; b < W; b++) begin
            q[idx].push_back(idx == 1 ? w[W-1-b] : w[b]);
        end
`ifdef DFFSRE_SER_PARITY_EN
        q[idx].push_back(^w);
`endif
        tick();
        load_w[idx] = 1'b0;
    endtask

    // Returns in the DONE cycle (#1 after the edge that raised DONE).
    task automatic wait_done(input int idx, input bit rnd);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (rnd) so_ready = 1'($urandom_range(0, 1));
            tick();
            if (done_w[idx]) seen = 1'b1;
        end
        so_ready = 1'b1;
        check($sformatf("d%0d_done_timeout", idx), int'(seen), 1);
    endtask

    task automatic wait_cnt(input int idx, input int n);
        for (int k = 0; k < 50 && m_cnt[idx] != n; k++) tick();
        check($sformatf("d%0d_cnt_reach", idx), m_cnt[idx], n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        R         = 1'b0;
        q_in      = 8'h00;
        so_ready  = 1'b1;
        load_w[0] = 1'b0;
        load_w[1] = 1'b0;
        tick();
        mon_on = 1'b1;
        tick();
        R = 1'b1;
        tick();

        // 1) A5 streamed LSB first with the sink always ready
        start(0, 8'hA5);
        wait_done(0, 1'b0);
        tick();

        // 2) three stall cycles after the 3rd transfer
        start(0, 8'hA5);
        wait_cnt(0, 3);
        so_ready = 1'b0;
        repeat (3) begin
            tick();
            check("stall_cnt", int'(cnt_w[0]), 3);
        end
        so_ready = 1'b1;
        wait_done(0, 1'b0);
        tick();

        // 3) LOAD with FF mid-frame must not disturb the A5 frame
        start(0, 8'hA5);
        tick();
        tick();
        load_w[0] = 1'b1;
        q_in      = 8'hFF;
        tick();
        load_w[0] = 1'b0;
        wait_done(0, 1'b0);
        tick();

        // 4) reset for two cycles after the 4th transfer, then a fresh frame
        start(0, 8'hA5);
        wait_cnt(0, 4);
        R = 1'b0;
        tick();
        check("rst_busy", int'(busy_w[0]), 0);
        tick();
        R = 1'b1;
        tick();
        start(0, 8'h3C);
        check("fresh_cnt", int'(cnt_w[0]), 0);
        wait_done(0, 1'b0);
        tick();

        // 5) MSB-first 80, then back-to-back LOAD in the DONE cycle
        start(1, 8'h80);
        wait_done(1, 1'b0);
        start(1, 8'h01);
        check("b2b_valid", int'(so_valid_w[1]), 1);
        wait_done(1, 1'b0);
        tick();

        // 6) parity cases (plain 8-bit frames when parity is not built in)
        start(0, 8'h07);
        wait_done(0, 1'b0);
        tick();
        start(0, 8'h03);
        wait_done(0, 1'b0);
        tick();

        // random words with a randomly stalling sink
        for (int f = 0; f < 4; f++) begin
            start(f % 2, 8'($urandom));
            wait_done(f % 2, 1'b1);
            tick();
        end

        tick();
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
